// File: rtl/satatrn_regfis_decode.sv
// Receive-side register FIS decoder: validates type/length, stages DWs, commits shadow registers atomically.
// Latency: pulses and fields update in the cycle after the deciding word; no backpressure, every valid word is consumed.
module satatrn_regfis_decode (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_link_err,
  input  logic        i_valid,
  input  logic [31:0] i_data,
  input  logic        i_last,
  output logic        o_fis_valid,
  output logic [7:0]  o_fis_type,
  output logic [7:0]  o_status,
  output logic [7:0]  o_error,
  output logic [7:0]  o_device,
  output logic [47:0] o_lba,
  output logic [15:0] o_count,
  output logic        o_intr,
  output logic        o_pio_dir,
  output logic [15:0] o_pio_xfer,
  output logic [7:0]  o_pio_estatus,
  output logic [31:0] o_sactive,
  output logic        o_dma_activate,
  output logic        o_bad_fis
);

  localparam logic [7:0] T_REG_D2H = 8'h34;
  localparam logic [7:0] T_PIO     = 8'h5F;
  localparam logic [7:0] T_DMA_ACT = 8'h39;
  localparam logic [7:0] T_SDB     = 8'hA1;

  typedef enum logic [1:0] {ST_IDLE, ST_BODY, ST_DISCARD} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] stg_q [0:4];
  logic [31:0] stg_d [0:4];
  logic [2:0]  len;
  logic        commit;
  logic        bad;

  // Expected length in DWs; zero marks an unsupported type.
  function automatic logic [2:0] fis_len(input logic [7:0] t);
    case (t)
      T_REG_D2H: return 3'd5;
      T_PIO:     return 3'd5;
      T_DMA_ACT: return 3'd1;
      T_SDB:     return 3'd2;
      default:   return 3'd0;
    endcase
  endfunction

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      for (int k = 0; k < 5; k++) stg_q[k] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      for (int k = 0; k < 5; k++) stg_q[k] <= stg_d[k];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    for (int k = 0; k < 5; k++) stg_d[k] = stg_q[k];
    len     = 3'd0;
    commit  = 1'b0;
    bad     = 1'b0;
    if (i_link_err) begin
      state_d = ST_IDLE;
      cnt_d   = 3'd0;
      for (int k = 0; k < 5; k++) stg_d[k] = '0;
    end else if (i_valid) begin
      case (state_q)
        ST_IDLE: begin
          stg_d[0] = i_data;
          cnt_d    = 3'd1;
          len      = fis_len(i_data[7:0]);
          if (len == 3'd0) begin
            bad = 1'b1;
            if (!i_last) state_d = ST_DISCARD;
          end else if (len == 3'd1) begin
            // A single-DW FIS that keeps going is over-length at DW0.
            if (i_last) commit = 1'b1;
            else begin
              bad     = 1'b1;
              state_d = ST_DISCARD;
            end
          end else if (i_last) begin
            bad = 1'b1;
          end else begin
            state_d = ST_BODY;
          end
        end
        ST_BODY: begin
          for (int k = 1; k < 5; k++)
            if (cnt_q == 3'(k)) stg_d[k] = i_data;
          cnt_d = cnt_q + 3'd1;
          len   = fis_len(stg_q[0][7:0]);
          if (cnt_q + 3'd1 == len) begin
            if (i_last) begin
              commit  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              bad     = 1'b1;
              state_d = ST_DISCARD;
            end
          end else if (i_last) begin
            bad     = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_DISCARD: begin
          if (i_last) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Commit reads stg_d so the final word lands in the same edge it arrives.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_fis_valid    <= 1'b0;
      o_fis_type     <= 8'h00;
      o_status       <= 8'h80;
      o_error        <= 8'h00;
      o_device       <= 8'h00;
      o_lba          <= 48'h0;
      o_count        <= 16'h0;
      o_intr         <= 1'b0;
      o_pio_dir      <= 1'b0;
      o_pio_xfer     <= 16'h0;
      o_pio_estatus  <= 8'h00;
      o_sactive      <= 32'h0;
      o_dma_activate <= 1'b0;
      o_bad_fis      <= 1'b0;
    end else begin
      o_fis_valid    <= commit;
      o_bad_fis      <= bad;
      o_intr         <= commit & stg_d[0][14];
      o_dma_activate <= commit && (stg_d[0][7:0] == T_DMA_ACT);
      if (commit) begin
        o_fis_type <= stg_d[0][7:0];
        case (stg_d[0][7:0])
          T_REG_D2H, T_PIO: begin
            o_status <= stg_d[0][23:16];
            o_error  <= stg_d[0][31:24];
            o_device <= stg_d[1][31:24];
            o_lba    <= {stg_d[2][23:0], stg_d[1][23:0]};
            o_count  <= stg_d[3][15:0];
            if (stg_d[0][7:0] == T_PIO) begin
              o_pio_dir     <= stg_d[0][13];
              o_pio_xfer    <= stg_d[4][15:0];
              o_pio_estatus <= stg_d[3][31:24];
            end
          end
          T_SDB: begin
            // BSY and DRQ are owned by the host-side protocol, not SDB.
            o_status  <= {o_status[7], stg_d[0][22:20], o_status[3], stg_d[0][18:16]};
            o_error   <= stg_d[0][31:24];
            o_sactive <= stg_d[1];
          end
          default: ;
        endcase
      end
    end
  end

endmodule
